// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions: instruction field constants, writeback source
// select encodings and the multiplier state encoding.
package mips_defs_pkg;

  // Primary opcodes
  localparam logic [5:0] OPCODE_RTYPE = 6'b000000;
  localparam logic [5:0] OPCODE_LUI   = 6'b001111;

  // R-type function codes that involve the HI/LO unit
  localparam logic [5:0] FUNC_MFHI = 6'b010000;
  localparam logic [5:0] FUNC_MFLO = 6'b010010;
  localparam logic [5:0] FUNC_MULT = 6'b011000;

  // Writeback mux select (regWriteDataSrc)
  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'b00,
    WB_SRC_LO  = 2'b01,
    WB_SRC_HI  = 2'b10,
    WB_SRC_LUI = 2'b11
  } wb_src_e;

  // Multiplier sequencing states; 2'b11 is unused and recovers to idle
  typedef enum logic [1:0] {
    MS_IDLE = 2'b00,
    MS_CALC = 2'b01,
    MS_FIX  = 2'b10
  } mult_state_e;

endpackage

// File: rtl/twos_negate.sv
// Conditional two's complement negate: y = neg ? -a : a.
// Used both to take operand magnitudes and to restore the product sign.
module twos_negate #(
  parameter int N = 32
) (
  input  logic         neg,
  input  logic [N-1:0] a,
  output logic [N-1:0] y
);

  // Negate by invert-plus-one; the most negative value maps onto itself,
  // which read as unsigned is exactly its magnitude.
  assign y = neg ? (~a + N'(1)) : a;

endmodule

// File: rtl/hilo_mult_unit.sv
// Multi-cycle signed multiplier with HI/LO result registers.
// Unsigned radix-2 shift-add on operand magnitudes (one multiplier bit per
// cycle, LSB first), then a single sign-fix cycle that commits {hi,lo}.
module hilo_mult_unit
  import mips_defs_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             multLoad,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mult_state_e        state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;
  logic [WIDTH-1:0]   mag_b;      // multiplier magnitude, shifted right each CALC cycle
  logic [2*WIDTH-1:0] mag_a_sh;   // multiplicand magnitude, shifted left each CALC cycle
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod;
  logic               neg;

  twos_negate #(.N(WIDTH)) u_mag_a (
    .neg (opA[WIDTH-1]),
    .a   (opA),
    .y   (mag_a_in)
  );

  twos_negate #(.N(WIDTH)) u_mag_b (
    .neg (opB[WIDTH-1]),
    .a   (opB),
    .y   (mag_b_in)
  );

  twos_negate #(.N(2*WIDTH)) u_prod (
    .neg (neg),
    .a   (acc),
    .y   (prod)
  );

  // Sequencer and datapath: capture operands, accumulate partial products, commit result.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register here is a handful of flops, not a RAM, so all of
    // them get the async reset; a reset mid-operation discards the partial product.
    if (rst) begin
      state    <= MS_IDLE;
      count    <= '0;
      mag_a_sh <= '0;
      mag_b    <= '0;
      acc      <= '0;
      neg      <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge values and the defaults below can be overridden safely.
      done <= 1'b0;
      case (state)
        MS_IDLE: begin
          // A request seen together with done is the retiring mult still
          // held by the controller; it must not start a second operation.
          if (multLoad && !done) begin
            mag_a_sh <= {{WIDTH{1'b0}}, mag_a_in};
            mag_b    <= mag_b_in;
            neg      <= opA[WIDTH-1] ^ opB[WIDTH-1];
            acc      <= '0;
            count    <= '0;
            state    <= MS_CALC;
          end
        end
        MS_CALC: begin
          if (mag_b[0]) begin
            acc <= acc + mag_a_sh;
          end
          mag_a_sh <= mag_a_sh << 1;
          mag_b    <= mag_b >> 1;
          count    <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH - 1)) begin
            state <= MS_FIX;
          end
        end
        MS_FIX: begin
          {hi, lo} <= prod;
          done     <= 1'b1;
          state    <= MS_IDLE;
        end
        default: begin
          state <= MS_IDLE;
        end
      endcase
    end
  end

  assign busy  = (state == MS_CALC) || (state == MS_FIX);
  // Stall from the request cycle itself; drop in the done cycle so the PC
  // steps past the mult exactly once.
  assign stall = busy | (multLoad & ~done);

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed bench for hilo_mult_unit: expected products go into a queue when
// a request is driven and are popped when done pulses.
module tb_hilo_mult_unit;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 2;   // request edge to done cycle

  logic             clk = 1'b0;
  logic             rst;
  logic             multLoad;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];
  logic [63:0] model_hilo;   // last committed product as the bench expects it

  hilo_mult_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .multLoad (multLoad),
    .opA      (opA),
    .opB      (opB),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Issue a request in the current cycle and follow it to its done cycle.
  // Returns in the done cycle with multLoad still high.
  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input bit perturb);
    int          cycles;
    bit          got;
    logic [63:0] exp;
    opA      = a;
    opB      = b;
    multLoad = 1'b1;
    exp_q.push_back(ref_mult(a, b));
    #1;
    check({tag, "_req_stall"}, 64'(stall), 64'd1);
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 3 * LAT) begin
      @(posedge clk);
      #1;
      cycles++;
      if (perturb) begin
        opA = $urandom;
        opB = $urandom;
      end
      if (done) begin
        got = 1'b1;
      end else begin
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_hold_hilo"}, {hi, lo}, model_hilo);
      end
    end
    check({tag, "_got_done"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(cycles), 64'(LAT));
    check({tag, "_done_stall"}, 64'(stall), 64'd0);
    check({tag, "_done_busy"}, 64'(busy), 64'd0);
    exp = exp_q.pop_front();
    check({tag, "_hilo"}, {hi, lo}, exp);
    model_hilo = exp;
  endtask

  // Release the request and confirm nothing restarts.
  task automatic drop_and_idle(input string tag);
    next_cycle();
    check({tag, "_after_done"}, 64'(done), 64'd0);
    check({tag, "_no_restart"}, 64'(busy), 64'd0);
    multLoad = 1'b0;
    #1;
    check({tag, "_idle_stall"}, 64'(stall), 64'd0);
    next_cycle();
    check({tag, "_still_idle"}, 64'(busy), 64'd0);
    check({tag, "_kept_hilo"}, {hi, lo}, model_hilo);
  endtask

  initial begin
    rst        = 1'b1;
    multLoad   = 1'b0;
    opA        = '0;
    opB        = '0;
    model_hilo = '0;
    #12;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();

    // Small positive product
    run_mult("p3x5", 32'd3, 32'd5, 1'b0);
    drop_and_idle("p3x5");

    // Reset while count is 10: abort, clear outputs immediately
    opA      = 32'd1234;
    opB      = 32'd5678;
    multLoad = 1'b1;
    for (int i = 0; i < 11; i++) next_cycle();
    check("mid_busy", 64'(busy), 64'd1);
    multLoad = 1'b0;
    rst      = 1'b1;
    #1;
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_stall", 64'(stall), 64'd0);
    model_hilo = '0;
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Signed cases; the first also shows a full-length run after reset
    run_mult("m7x6", 32'hFFFF_FFF9, 32'd6, 1'b0);
    drop_and_idle("m7x6");
    run_mult("m7xm6", 32'hFFFF_FFF9, 32'hFFFF_FFFA, 1'b0);
    drop_and_idle("m7xm6");

    // Extremes, issued back to back one cycle after done
    run_mult("min_sq", 32'h8000_0000, 32'h8000_0000, 1'b0);
    next_cycle();
    run_mult("max_min", 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    drop_and_idle("max_min");

    // Operand churn during CALC must not affect the captured operands
    run_mult("perturb", 32'h0001_2345, 32'hFFFE_DCBA, 1'b1);
    opA = 32'h0;
    opB = 32'h0;
    drop_and_idle("perturb");

    // Zero operand still takes the full latency; prior hi/lo held while busy
    run_mult("zero", 32'h0, 32'h1234_5678, 1'b0);
    drop_and_idle("zero");

    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
